mos6502s_pointer_fetch: RTL and testbench
=========================================

# mos6502s_pointer_fetch

Sequential pointer-fetch stage for the MOS 6502 core, directly downstream of the indirect address calculator. It takes the two pointer byte addresses produced for indirect modes, reads the low and high pointer bytes through a single-byte memory read port with a ready handshake, and assembles the 16-bit effective address. For (zp),Y it adds Y and reports page crossing. It hands the result to the operand-fetch/execute stage with a one-cycle done pulse.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- mode  in  4  addressing mode: 4'h9 indirect, 4'hA (zp,X), 4'hB (zp),Y
- ptr_addr_lo  in  16  address of pointer low byte (from indirect address calc)
- ptr_addr_hi  in  16  address of pointer high byte (from indirect address calc)
- y_reg  in  8  Y index, used for mode 4'hB
- mem_addr  out  16  read address
- mem_rd  out  1  read request
- mem_rdata  in  8  read data, valid when mem_ready=1 while mem_rd=1
- mem_ready  in  1  read completion; may be held low for any number of cycles
- eff_addr  out  16  assembled effective address
- page_cross  out  1  carry out of low-byte Y addition (mode 4'hB only)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse; eff_addr/page_cross valid

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, FIX (only with the macro), DONE.
- IDLE: start=1 with mode ∈ {9,A,B} latches mode, ptr_addr_lo, ptr_addr_hi, y_reg, then goes to FETCH_LO. start with any other mode is ignored; the block stays in IDLE and does no read.
- FETCH_LO: mem_rd=1, mem_addr=latched ptr_addr_lo. On mem_ready=1, capture mem_rdata as lo and go to FETCH_HI.
- FETCH_HI: mem_rd=1, mem_addr=latched ptr_addr_hi. On mem_ready=1, capture hi and compute the result:
  - mode 9/A: eff_addr={hi,lo}, page_cross=0.
  - mode B: eff_addr=({hi,lo}+{8'h00,y}) mod 2^16, page_cross=carry out of lo+y.
  - Next state is DONE, or FIX when the macro is enabled and page_cross=1.
- FIX: dummy read at {hi, (lo+y)[7:0]}; on mem_ready=1 go to DONE. The data is discarded.
- DONE: done=1 for exactly this cycle, then IDLE.
- Address wrap is the caller's responsibility, because the pointer addresses arrive pre-wrapped. The FFFF+Y result wraps to page 0 with page_cross=1.
- eff_addr and page_cross hold their last values until the next FETCH_HI completion.
- start while busy is ignored and not queued.
- Input changes after the start cycle have no effect, because all inputs are latched.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE; mem_rd=0, mem_addr=0, eff_addr=0, page_cross=0, busy=0, done=0.
- Reset mid-operation aborts the operation. mem_rd is 0 from the next cycle, and no done pulse is produced.
- Zero-wait latency (mem_ready tied 1), start sampled at edge 0:
  - FETCH_LO in cycle 1, FETCH_HI in cycle 2, done=1 in cycle 3.
  - With FIX: done=1 in cycle 4.
- Each wait cycle (mem_ready=0) adds one cycle. mem_addr and mem_rd stay stable throughout the wait.
- mem_rd is combinational from state. mem_rdata is sampled only at the edge where mem_rd=1 and mem_ready=1.
- busy=1 from cycle 1 through the DONE cycle inclusive. A new start is accepted in the cycle after DONE.

## Configuration
- MOS6502S_PAGE_CROSS_DUMMY_READ_EN
  - Defined: FIX state exists. Mode B with page_cross=1 issues one extra dummy read at the unfixed address before done, which is cycle-accurate to the NMOS bus behaviour.
  - Undefined: no FIX state, so done always arrives 3 cycles after start at zero wait. page_cross is still reported for the downstream cycle counter.

## Structure
- Shared package mos6502s_pkg holds:
  - MODE_INDIRECT=4'h9, MODE_INDEXED_IND=4'hA, MODE_INDIRECT_IDX=4'hB;
  - the pointer-fetch state encoding.
- One sub-module, mos6502s_index_adder: 16-bit base + 8-bit index, producing a 16-bit sum, the unfixed address {base_hi, sum_lo}, and a carry-out. It is combinational and reusable by the absolute,X/Y path.
- FSM and capture registers live in mos6502s_pointer_fetch.

## Test plan
- Mode 9, ptr_lo=16'h30FF, ptr_hi=16'h3000, mem[30FF]=8'h34, mem[3000]=8'h12, mem_ready=1 → reads at 30FF then 3000; eff_addr=16'h1234, page_cross=0, done in cycle 3.
- Mode B, ptr_lo=16'h0080, ptr_hi=16'h0081, mem=8'hF0,8'h20, y=8'h20 → eff_addr=16'h2110, page_cross=1.
  - Macro defined: dummy read at 16'h2010, done in cycle 4.
  - Macro undefined: done in cycle 3.
- Mode A, mem_ready low 2 cycles per read → mem_addr stable while waiting; done in cycle 7; eff_addr matches the fetched bytes.
- Mode B, pointer=16'hFFFF, y=8'h01 → eff_addr=16'h0000, page_cross=1.
- start with mode=4'h3 → no mem_rd and busy stays 0; start during busy → ignored, exactly one done.
- rst_n=0 during FETCH_HI → next cycle IDLE, mem_rd=0, all outputs 0, no done.

Source files
------------

// File: rtl/mos6502s_pkg.sv
// mos6502s_pkg: shared addressing-mode codes and pointer-fetch state encoding
package mos6502s_pkg;
    localparam logic [3:0] MODE_INDIRECT     = 4'h9;
    localparam logic [3:0] MODE_INDEXED_IND  = 4'hA;
    localparam logic [3:0] MODE_INDIRECT_IDX = 4'hB;

    typedef enum logic [2:0] {
        PF_IDLE,
        PF_FETCH_LO,
        PF_FETCH_HI,
        PF_FIX,
        PF_DONE
    } pf_state_t;
endpackage

// File: rtl/mos6502s_index_adder.sv
// mos6502s_index_adder: 16-bit base plus 8-bit index with unfixed address and low-byte carry
// Ports: base/index in; sum = base+index, unfixed = {base_hi, sum_lo}, carry = carry out of low byte
module mos6502s_index_adder (
    input  logic [15:0] base,
    input  logic [7:0]  index,
    output logic [15:0] sum,
    output logic [15:0] unfixed,
    output logic        carry
);
    logic [8:0] lo_sum;
    assign lo_sum  = {1'b0, base[7:0]} + {1'b0, index};
    assign sum     = base + {8'h00, index};
    assign unfixed = {base[15:8], lo_sum[7:0]};
    assign carry   = lo_sum[8];
endmodule

// File: rtl/mos6502s_pointer_fetch.sv
// mos6502s_pointer_fetch: reads indirect pointer bytes and assembles the effective address
// Ports: clk, rst_n (sync, active-low); start/mode/ptr_addr_lo/ptr_addr_hi/y_reg request;
//        mem_addr/mem_rd/mem_rdata/mem_ready byte read port; eff_addr/page_cross/busy/done result.
// MOS6502S_PAGE_CROSS_DUMMY_READ_EN adds the NMOS dummy read at the unfixed address on page cross.
module mos6502s_pointer_fetch
    import mos6502s_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic [15:0] ptr_addr_lo,
    input  logic [15:0] ptr_addr_hi,
    input  logic [7:0]  y_reg,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] eff_addr,
    output logic        page_cross,
    output logic        busy,
    output logic        done
);
    pf_state_t   state, state_nx;
    logic        idx_q;
    logic [15:0] ptr_lo_q, ptr_hi_q, fix_addr;
    logic [7:0]  y_q, lo_q;
    logic [15:0] sum, unfixed;
    logic        carry, mode_ok, fix_needed;

    assign mode_ok = mode inside {MODE_INDIRECT, MODE_INDEXED_IND, MODE_INDIRECT_IDX};

    // Non-indexed modes add zero, so carry (and page_cross) is naturally 0 for them.
    mos6502s_index_adder u_adder (
        .base    ({mem_rdata, lo_q}),
        .index   (idx_q ? y_q : 8'h00),
        .sum     (sum),
        .unfixed (unfixed),
        .carry   (carry)
    );

`ifdef MOS6502S_PAGE_CROSS_DUMMY_READ_EN
    assign fix_needed = carry;
`else
    assign fix_needed = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        mem_addr = 16'h0000;
        unique case (state)
            PF_IDLE:     state_nx = (start && mode_ok) ? PF_FETCH_LO : PF_IDLE;
            PF_FETCH_LO: begin
                mem_rd   = 1'b1;
                mem_addr = ptr_lo_q;
                state_nx = mem_ready ? PF_FETCH_HI : PF_FETCH_LO;
            end
            PF_FETCH_HI: begin
                mem_rd   = 1'b1;
                mem_addr = ptr_hi_q;
                state_nx = !mem_ready ? PF_FETCH_HI : fix_needed ? PF_FIX : PF_DONE;
            end
            PF_FIX: begin
                mem_rd   = 1'b1;
                mem_addr = fix_addr;
                state_nx = mem_ready ? PF_DONE : PF_FIX;
            end
            PF_DONE:     state_nx = PF_IDLE;
            default:     state_nx = PF_IDLE;
        endcase
    end

    assign busy = state != PF_IDLE;
    assign done = state == PF_DONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= PF_IDLE;
            eff_addr   <= 16'h0000;
            page_cross <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == PF_IDLE && start && mode_ok) begin
                idx_q    <= mode == MODE_INDIRECT_IDX;
                ptr_lo_q <= ptr_addr_lo;
                ptr_hi_q <= ptr_addr_hi;
                y_q      <= y_reg;
            end
            if (state == PF_FETCH_LO && mem_ready)
                lo_q <= mem_rdata;
            if (state == PF_FETCH_HI && mem_ready) begin
                eff_addr   <= sum;
                page_cross <= carry;
                fix_addr   <= unfixed;
            end
        end
    end
endmodule

// File: tb/tb_mos6502s_pointer_fetch.sv
// tb_mos6502s_pointer_fetch: randomized bench against a byte-memory reference model
module tb_mos6502s_pointer_fetch;
    logic        clk = 1'b0;
    logic        rst_n, start, mem_rd, mem_ready, page_cross, busy, done;
    logic [3:0]  mode;
    logic [15:0] ptr_addr_lo, ptr_addr_hi, mem_addr, eff_addr;
    logic [7:0]  y_reg, mem_rdata;
    logic [7:0]  mem [0:65535];
    logic [15:0] eff_o;
    logic        pc_o;
    int          n_checks = 0, n_errors = 0;

`ifdef MOS6502S_PAGE_CROSS_DUMMY_READ_EN
    localparam bit FIX_EN = 1'b1;
`else
    localparam bit FIX_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    // Data is scrambled while not ready so early sampling is visible.
    assign mem_rdata = mem_ready ? mem[mem_addr] : ~mem[mem_addr];

    mos6502s_pointer_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .ptr_addr_lo (ptr_addr_lo),
        .ptr_addr_hi (ptr_addr_hi),
        .y_reg       (y_reg),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .eff_addr    (eff_addr),
        .page_cross  (page_cross),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction with w wait cycles before every read completes.
    task automatic run(input logic [3:0] m, input logic [15:0] plo, input logic [15:0] phi,
                       input logic [7:0] y, input int w, output logic [15:0] eff_r, output logic pc_r);
        int lo_b, hi_b, add, lsum, full, exp_cycles, wcnt;
        bit pc, got_done;
        logic [15:0] addrs [$];
        lo_b = int'(mem[plo]);
        hi_b = int'(mem[phi]);
        add  = (m == 4'hB) ? int'(y) : 0;
        lsum = lo_b + add;
        pc   = lsum > 255;
        full = (hi_b * 256 + lo_b + add) % 65536;
        addrs = {plo, phi};
        if (FIX_EN && pc) addrs.push_back(16'(hi_b * 256 + lsum % 256));
        exp_cycles = addrs.size() * (w + 1) + 1;
        eff_r = 16'h0000;
        pc_r = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = m; ptr_addr_lo = plo; ptr_addr_hi = phi; y_reg = y;
        @(posedge clk);
        wcnt = 0;
        got_done = 0;
        for (int cyc = 1; cyc <= 60 && !got_done; cyc++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            mode = {2'b10, 2'($urandom)};
            ptr_addr_lo = 16'($urandom);
            ptr_addr_hi = 16'($urandom);
            y_reg = 8'($urandom);
            check("busy", busy, 1);
            if (done) begin
                got_done = 1;
                start = 1'b0;
                check("latency", cyc, exp_cycles);
                check("eff_addr", eff_addr, full);
                check("page_cross", page_cross, pc);
                check("reads_left", addrs.size(), 0);
                eff_r = eff_addr;
                pc_r = page_cross;
            end else begin
                check("mem_rd", mem_rd, 1);
                if (addrs.size() == 0) check("extra_read", mem_rd, 0);
                else begin
                    check("mem_addr", mem_addr, addrs[0]);
                    mem_ready = (wcnt == w);
                    if (mem_ready) begin
                        void'(addrs.pop_front());
                        wcnt = 0;
                    end else wcnt++;
                end
            end
        end
        check("timeout", got_done, 1);
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("single_done", done, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0; start = 1'b0; mode = 4'h0; ptr_addr_lo = 16'h0; ptr_addr_hi = 16'h0;
        y_reg = 8'h0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_eff", eff_addr, 0);
        check("rst_pc", page_cross, 0);
        rst_n = 1'b1;

        mem[16'h30FF] = 8'h34; mem[16'h3000] = 8'h12;
        run(4'h9, 16'h30FF, 16'h3000, 8'h55, 0, eff_o, pc_o);
        check("tp1_eff", eff_o, 16'h1234);
        check("tp1_pc", pc_o, 0);

        mem[16'h0080] = 8'hF0; mem[16'h0081] = 8'h20;
        run(4'hB, 16'h0080, 16'h0081, 8'h20, 0, eff_o, pc_o);
        check("tp2_eff", eff_o, 16'h2110);
        check("tp2_pc", pc_o, 1);

        mem[16'h0044] = 8'hCD; mem[16'h0045] = 8'hAB;
        run(4'hA, 16'h0044, 16'h0045, 8'hFF, 2, eff_o, pc_o);
        check("tp3_eff", eff_o, 16'hABCD);
        check("tp3_pc", pc_o, 0);

        mem[16'h0010] = 8'hFF; mem[16'h0011] = 8'hFF;
        run(4'hB, 16'h0010, 16'h0011, 8'h01, 1, eff_o, pc_o);
        check("tp4_eff", eff_o, 16'h0000);
        check("tp4_pc", pc_o, 1);

        foreach (mode[i]) begin end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b1;
            mode = (k == 0) ? 4'h3 : (k == 1) ? 4'h8 : 4'hF;
            repeat (3) begin
                @(negedge clk);
                check("bad_mode_busy", busy, 0);
                check("bad_mode_rd", mem_rd, 0);
            end
            start = 1'b0;
        end

        for (int t = 0; t < 40; t++)
            run(4'h9 + 4'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 8'($urandom),
                $urandom_range(0, 3), eff_o, pc_o);

        @(negedge clk);
        mem_ready = 1'b1; start = 1'b1; mode = 4'h9; ptr_addr_lo = 16'h1200; ptr_addr_hi = 16'h1201;
        @(negedge clk);
        start = 1'b0;
        check("abort_lo_addr", mem_addr, 16'h1200);
        @(negedge clk);
        check("abort_hi_addr", mem_addr, 16'h1201);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_rd", mem_rd, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_eff", eff_addr, 0);
        check("abort_pc", page_cross, 0);
        check("abort_done", done, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
